// File: rtl/sys_cmd_pkg.sv
// Shared constants and types for the system command master: opcode bytes,
// request encodings, FSM states and per-command frame/response sizes.
package sys_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    REQ_WR      = 2'd0,
    REQ_RD      = 2'd1,
    REQ_ALU_OP  = 2'd2,
    REQ_ALU_NOP = 2'd3
  } req_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam int FRAME_LEN_WR      = 3;
  localparam int FRAME_LEN_RD      = 2;
  localparam int FRAME_LEN_ALU_OP  = 4;
  localparam int FRAME_LEN_ALU_NOP = 2;

  localparam int RESP_BYTES_WR = 0;
  localparam int RESP_BYTES_RD = 1;

  // Index of the final frame byte, used as the SEND terminal count.
  function automatic logic [1:0] frameLastIdx(input req_cmd_e cmd);
    logic [1:0] idx;
    idx = 2'(FRAME_LEN_ALU_NOP - 1);
    case (cmd)
      REQ_WR:      idx = 2'(FRAME_LEN_WR - 1);
      REQ_RD:      idx = 2'(FRAME_LEN_RD - 1);
      REQ_ALU_OP:  idx = 2'(FRAME_LEN_ALU_OP - 1);
      REQ_ALU_NOP: idx = 2'(FRAME_LEN_ALU_NOP - 1);
      default:     idx = 2'(FRAME_LEN_ALU_NOP - 1);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Response timeout counter for sys_cmd_master. Only instanced when the
// CMD_TIMEOUT_EN build option is defined. Counts enabled cycles since the
// last clear and flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Count up while enabled, saturating at the terminal value; clear wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else if (i_enable && (r_count != LAST))
      r_count <= r_count + CW'(1);
  end

  assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/sys_cmd_master.sv
// Host-side command issuer: accepts one request, serialises its frame to the
// UART TX byte interface, collects response bytes from UART RX and returns
// the assembled little-endian result.
// Build option: define CMD_TIMEOUT_EN to add a response timeout (resp_err=1).
import sys_cmd_pkg::*;

module sys_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_RESP_BYTES = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_cmd,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH-1:0]   req_op_a,
  input  logic [DATA_WIDTH-1:0]   req_op_b,
  input  logic [3:0]              req_fun,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [2*DATA_WIDTH-1:0] resp_data,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic                    busy
);

  localparam logic [1:0] ALU_EXPECT = 2'(ALU_RESP_BYTES);

  state_e                        r_state;
  state_e                        w_nextState;
  logic [3:0][DATA_WIDTH-1:0]    r_frame;
  logic [1:0]                    r_txIdx;
  logic [1:0]                    r_lastIdx;
  logic [1:0]                    r_expect;
  logic [1:0]                    r_rxCnt;
  logic [2*DATA_WIDTH-1:0]       r_respData;
  logic                          w_accept;
  logic                          w_txLast;
  logic                          w_rxFinal;
  logic                          w_timeout;
  logic [DATA_WIDTH-1:0]         w_addrByte;
  logic [DATA_WIDTH-1:0]         w_funByte;

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_txLast   = tx_ready && (r_txIdx == r_lastIdx);
  assign w_rxFinal  = rx_valid && ((r_rxCnt + 2'd1) == r_expect);
  assign w_addrByte = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, req_addr};
  assign w_funByte  = {{(DATA_WIDTH-4){1'b0}}, req_fun};

`ifdef CMD_TIMEOUT_EN
  logic w_expire;
  logic r_err;

  cmd_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .i_clear (r_state != ST_WAIT_RESP || rx_valid),
    .i_enable(r_state == ST_WAIT_RESP),
    .o_expire(w_expire)
  );

  // A received byte in the expiry cycle takes priority over the timeout.
  assign w_timeout = (r_state == ST_WAIT_RESP) && w_expire && !rx_valid;

  // Error flag: cleared by a new request, set when the wait expires.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_err <= 1'b0;
    else if (w_accept)
      r_err <= 1'b0;
    else if (w_timeout)
      r_err <= 1'b1;
  end

  assign resp_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  // Next-state logic; writes expect no response and skip the wait.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:      if (req_valid) w_nextState = ST_SEND;
      ST_SEND:      if (w_txLast)  w_nextState = (r_expect == 2'd0) ? ST_DONE : ST_WAIT_RESP;
      ST_WAIT_RESP: if (w_rxFinal || w_timeout) w_nextState = ST_DONE;
      ST_DONE:      w_nextState = ST_IDLE;
      default:      w_nextState = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; tx_data reads the current frame byte.
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    busy       = (r_state != ST_IDLE);
    tx_valid   = (r_state == ST_SEND);
    tx_data    = (r_state == ST_SEND) ? r_frame[r_txIdx] : '0;
    resp_valid = (r_state == ST_DONE);
    resp_data  = r_respData;
  end

  // Frame latch on acceptance, TX byte stepping and RX byte assembly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_frame    <= '0;
      r_txIdx    <= 2'd0;
      r_lastIdx  <= 2'd0;
      r_expect   <= 2'd0;
      r_rxCnt    <= 2'd0;
      r_respData <= '0;
    end else begin
      if (w_accept) begin
        r_txIdx    <= 2'd0;
        r_rxCnt    <= 2'd0;
        r_respData <= '0;
        r_lastIdx  <= frameLastIdx(req_cmd_e'(req_cmd));
        case (req_cmd_e'(req_cmd))
          REQ_WR: begin
            r_frame  <= {{DATA_WIDTH{1'b0}}, req_wdata, w_addrByte, CMD_WR};
            r_expect <= 2'(RESP_BYTES_WR);
          end
          REQ_RD: begin
            r_frame  <= {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}, w_addrByte, CMD_RD};
            r_expect <= 2'(RESP_BYTES_RD);
          end
          REQ_ALU_OP: begin
            r_frame  <= {w_funByte, req_op_b, req_op_a, CMD_ALU_OP};
            r_expect <= ALU_EXPECT;
          end
          default: begin
            r_frame  <= {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}, w_funByte, CMD_ALU_NOP};
            r_expect <= ALU_EXPECT;
          end
        endcase
      end
      if ((r_state == ST_SEND) && tx_ready && !w_txLast)
        r_txIdx <= r_txIdx + 2'd1;
      if ((r_state == ST_WAIT_RESP) && rx_valid) begin
        if (r_rxCnt[0])
          r_respData[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_data;
        else
          r_respData[DATA_WIDTH-1:0] <= rx_data;
        r_rxCnt <= r_rxCnt + 2'd1;
      end
    end
  end

endmodule
